// File: rtl/mul_acc_pkg.sv
// Shared types and default sizing for the multiply-accumulate readout stage.
//   state_t    : sequencer state (IDLE = no samples, ACCUM = samples held, DRAIN = readout)
//   ACC_BYTES  : bytes in the default-width accumulator
//   NB         : bytes per readout (accumulator bytes plus one count byte)
//   BIDX_W     : width of a byte index covering NB bytes
package mul_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DEF_ACC_W = 16;
  localparam int ACC_BYTES = DEF_ACC_W / 8;
  localparam int NB        = ACC_BYTES + 1;
  localparam int BIDX_W    = $clog2(NB);

endpackage

// File: rtl/mul_acc_sat_add.sv
// Zero-extended unsigned add of a product into the accumulator, clamped to the
// accumulator's full-scale value.
//   acc     in  ACC_W   current accumulator value
//   product in  PROD_W  unsigned product to add
//   sum     out ACC_W   clamped sum
//   sat     out 1       high when the true sum exceeded full scale
module mul_acc_sat_add #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 16
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] product,
  output logic [ACC_W-1:0]  sum,
  output logic              sat
);

  // One guard bit catches the carry out of the accumulator width.
  logic [ACC_W:0] wide;

  assign wide = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, product};
  assign sat  = wide[ACC_W];
  assign sum  = sat ? {ACC_W{1'b1}} : wide[ACC_W-1:0];

endmodule

// File: rtl/mul_acc_sequencer.sv
// Multiply-accumulate back end: accumulates unsigned products into a saturating
// accumulator with a saturating sample count, and on request streams
// {count byte, accumulator} out one byte per enabled cycle, accumulator LSB first.
//   clk, rst_n        clock, asynchronous active-low reset
//   ena               enable; low freezes state and drops out_valid
//   clr               synchronous clear of acc/cnt/ovf, aborts a readout
//   in_valid/in_ready product handshake (in_ready low only while draining)
//   product           unsigned product from the multiplier
//   rd_req            start a readout (ignored while draining)
//   out_byte/out_valid/out_last  readout stream, out_last on the count byte
//   busy              readout in progress
//   ovf               sticky accumulator saturation flag
module mul_acc_sequencer
  import mul_acc_pkg::*;
#(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] product,
  input  logic              rd_req,
  output logic [7:0]        out_byte,
  output logic              out_valid,
  output logic              out_last,
  output logic              busy,
  output logic              ovf
);

  localparam int NBYTES = ACC_W / 8 + 1;
  localparam int IDX_W  = $clog2(NBYTES);
  localparam int SH_W   = ACC_W + 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_t            state_q;
  logic [ACC_W-1:0]  acc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [SH_W-1:0]   sh_q;
  logic [IDX_W-1:0]  idx_q;

  logic              accept;
  logic              add_sat;
  logic [ACC_W-1:0]  add_sum;
  logic [ACC_W-1:0]  acc_nx;
  logic [CNT_W-1:0]  cnt_nx;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  // Low 8 bits of the count, zero-extended when the counter is narrower.
  function automatic logic [7:0] cnt_byte(input logic [CNT_W-1:0] c);
    logic [CNT_W+7:0] w;
    w = {8'd0, c};
    return w[7:0];
  endfunction

  assign in_ready = (state_q != DRAIN);
  assign accept   = ena & in_valid & in_ready & ~clr;

  mul_acc_sat_add #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_sat_add (
    .acc     (acc_q),
    .product (product),
    .sum     (add_sum),
    .sat     (add_sat)
  );

  // A same-cycle accept is folded in before any snapshot is taken.
  assign acc_nx = accept ? add_sum : acc_q;
  assign cnt_nx = accept ? sat_inc(cnt_q) : cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      sh_q      <= '0;
      idx_q     <= '0;
      ovf       <= 1'b0;
      out_byte  <= 8'd0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else if (clr) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      sh_q      <= '0;
      idx_q     <= '0;
      ovf       <= 1'b0;
      out_byte  <= 8'd0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else if (!ena) begin
      // Frozen; the stream pauses and resumes on the same byte.
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (state_q == DRAIN) begin
      out_byte  <= sh_q[7:0];
      sh_q      <= sh_q >> 8;
      out_valid <= 1'b1;
      out_last  <= (idx_q == LAST_IDX);
      if (idx_q == LAST_IDX) begin
        idx_q   <= '0;
        busy    <= 1'b0;
        state_q <= (cnt_q != '0) ? ACCUM : IDLE;
      end else begin
        idx_q   <= idx_q + 1'b1;
      end
    end else begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      acc_q     <= acc_nx;
      cnt_q     <= cnt_nx;
      if (accept && add_sat)
        ovf <= 1'b1;
      if (rd_req) begin
        sh_q    <= {cnt_byte(cnt_nx), acc_nx};
        idx_q   <= '0;
        busy    <= 1'b1;
        state_q <= DRAIN;
      end else begin
        state_q <= (cnt_nx != '0) ? ACCUM : IDLE;
      end
    end
  end

endmodule

// File: tb/tb_mul_acc_sequencer.sv
module tb_mul_acc_sequencer;

  localparam int NBYTES = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       clr;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] product;
  logic       rd_req;
  logic [7:0] out_byte;
  logic       out_valid;
  logic       out_last;
  logic       busy;
  logic       ovf;

  int checks   = 0;
  int failures = 0;

  // Reference model: running sums plus a queue of bytes still to be streamed.
  int         m_acc;
  int         m_cnt;
  bit         m_ovf;
  logic [7:0] m_q[$];
  logic [7:0] e_byte;
  bit         e_valid;
  bit         e_last;

  // Bytes observed on the stream, for explicit sequence checks.
  logic [7:0] got_b[$];
  bit         got_l[$];

  always #5 clk = ~clk;

  mul_acc_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .product   (product),
    .rd_req    (rd_req),
    .out_byte  (out_byte),
    .out_valid (out_valid),
    .out_last  (out_last),
    .busy      (busy),
    .ovf       (ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_cnt = 0; m_ovf = 0;
    m_q.delete();
    e_byte = 8'd0; e_valid = 0; e_last = 0;
  endtask

  task automatic model_edge(input bit en, input bit iv, input int prod, input bit rd, input bit c);
    if (c) begin
      model_reset();
    end else if (!en) begin
      e_valid = 0; e_last = 0;
    end else if (m_q.size() != 0) begin
      e_byte  = m_q.pop_front();
      e_valid = 1;
      e_last  = (m_q.size() == 0);
    end else begin
      e_valid = 0; e_last = 0;
      if (iv) begin
        m_acc = m_acc + prod;
        if (m_acc > 65535) begin
          m_acc = 65535;
          m_ovf = 1;
        end
        if (m_cnt < 255) m_cnt++;
      end
      if (rd) begin
        m_q.push_back(m_acc[7:0]);
        m_q.push_back(m_acc[15:8]);
        m_q.push_back(m_cnt[7:0]);
      end
    end
  endtask

  task automatic check_outputs(input string ph);
    chk({ph, ".out_valid"}, out_valid, e_valid);
    chk({ph, ".out_last"},  out_last,  e_last);
    chk({ph, ".out_byte"},  out_byte,  e_byte);
    chk({ph, ".in_ready"},  in_ready,  m_q.size() == 0);
    chk({ph, ".busy"},      busy,      m_q.size() != 0);
    chk({ph, ".ovf"},       ovf,       m_ovf);
  endtask

  task automatic step(input string ph, input bit en, input bit iv, input int prod,
                      input bit rd, input bit c);
    ena = en; in_valid = iv; product = prod[7:0]; rd_req = rd; clr = c;
    @(posedge clk);
    model_edge(en, iv, prod, rd, c);
    @(negedge clk);
    check_outputs(ph);
    if (out_valid === 1'b1) begin
      got_b.push_back(out_byte);
      got_l.push_back(out_last);
    end
  endtask

  task automatic check_seq(input string ph, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2);
    logic [7:0] exp_b[3];
    exp_b[0] = b0; exp_b[1] = b1; exp_b[2] = b2;
    chk({ph, ".nbytes"}, got_b.size(), NBYTES);
    for (int i = 0; i < NBYTES && i < got_b.size(); i++) begin
      chk($sformatf("%s.byte%0d", ph, i), got_b[i], exp_b[i]);
      chk($sformatf("%s.last%0d", ph, i), got_l[i], i == NBYTES - 1);
    end
  endtask

  // Request a readout (optionally with a same-cycle product) and run it to completion.
  task automatic readout(input string ph, input bit iv, input int prod,
                         input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    got_b.delete(); got_l.delete();
    step({ph, ".req"}, 1, iv, prod, 1, 0);
    for (int i = 0; i < NBYTES + 1; i++) step({ph, ".drain"}, 1, 0, 0, 0, 0);
    check_seq(ph, b0, b1, b2);
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; clr = 1'b0; in_valid = 1'b0; product = 8'd0; rd_req = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs("reset");
    chk("reset.in_ready_hi", in_ready, 1);
    rst_n = 1'b1;

    // Basic accumulate and readout.
    step("t1", 1, 1, 10, 0, 0);
    step("t1", 1, 1, 20, 0, 0);
    step("t1", 1, 1, 30, 0, 0);
    readout("t1", 0, 0, 8'h3C, 8'h00, 8'h03);
    chk("t1.ovf", ovf, 0);

    // Saturation of accumulator and counter.
    step("t2.clr", 1, 0, 0, 0, 1);
    for (int i = 0; i < 258; i++) step("t2", 1, 1, 255, 0, 0);
    chk("t2.ovf", ovf, 1);
    readout("t2", 0, 0, 8'hFF, 8'hFF, 8'hFF);

    // Accept and read in the same cycle: snapshot includes the product.
    step("t3.clr", 1, 0, 0, 0, 1);
    step("t3", 1, 1, 7, 0, 0);
    readout("t3", 1, 5, 8'h0C, 8'h00, 8'h02);

    // Clear during the drain aborts it.
    step("t4.clr", 1, 0, 0, 0, 1);
    step("t4", 1, 1, 100, 0, 0);
    step("t4.req", 1, 0, 0, 1, 0);
    step("t4.b0", 1, 0, 0, 0, 0);
    step("t4.clr2", 1, 1, 9, 1, 1);
    chk("t4.abort_valid", out_valid, 0);
    chk("t4.abort_ready", in_ready, 1);
    chk("t4.abort_byte", out_byte, 0);
    step("t4.idle", 1, 0, 0, 0, 0);
    readout("t4.after", 0, 0, 8'h00, 8'h00, 8'h00);

    // Enable gap inside the drain.
    step("t5.clr", 1, 0, 0, 0, 1);
    step("t5", 1, 1, 8'hAB, 0, 0);
    step("t5", 1, 1, 8'hCD, 0, 0);
    got_b.delete(); got_l.delete();
    step("t5.req", 1, 0, 0, 1, 0);
    step("t5.b0", 1, 0, 0, 0, 0);
    step("t5.b1", 1, 0, 0, 0, 0);
    step("t5.gap", 0, 1, 3, 1, 0);
    step("t5.gap", 0, 0, 0, 0, 0);
    step("t5.b2", 1, 0, 0, 0, 0);
    step("t5.post", 1, 0, 0, 0, 0);
    check_seq("t5", 8'h78, 8'h01, 8'h02);

    // Asynchronous reset in the middle of a drain.
    step("t6", 1, 1, 50, 0, 0);
    step("t6.req", 1, 0, 0, 1, 0);
    step("t6.b0", 1, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("t6.async");
    @(negedge clk);
    rst_n = 1'b1;
    step("t6.idle", 1, 0, 0, 0, 0);
    readout("t6.after", 0, 0, 8'h00, 8'h00, 8'h00);

    // Randomized traffic against the model.
    step("rnd.clr", 1, 0, 0, 0, 1);
    for (int i = 0; i < 600; i++) begin
      bit en, iv, rd, c;
      int prod;
      en   = ($urandom_range(0, 9) != 0);
      iv   = $urandom_range(0, 1);
      prod = ($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 255);
      rd   = ($urandom_range(0, 11) == 0);
      c    = ($urandom_range(0, 79) == 0);
      step("rnd", en, iv, prod, rd, c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
